vrf_operand_fetch: RTL and testbench

- Operand-fetch stage directly upstream of the vector register file (VRF); sits between vector issue and the vector execution lanes.
- Accepts one decoded vector micro-op per handshake and drives both VRF read addresses.
- Retries reads that collide with a VRF write, because a write suppresses read port 1.
- Snoops the element-masked writeback bus and forwards it into held operands; presents vs1/vs2 operand vectors to execute over valid/ready.

---
 rtl/vrf_operand_fetch.sv | 104 ++++++++++
 tb/tb_vrf_operand_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_operand_fetch.sv
// Vector operand fetch: drives both VRF reads, retries reads hit by a write, forwards writebacks into held operands.
// Latency 2 cycles from a write-free accept (+1 per colliding write cycle); operands held and kept forwarded under out_ready=0.
module vrf_operand_fetch #(
    parameter int  VREGS      = 32,
    parameter int  ELEMENTS   = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  TAG_WIDTH  = 16,
    localparam int AW         = $clog2(VREGS)
) (
    input  logic                                 clk_i,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [AW-1:0]                        in_vs1,
    input  logic [AW-1:0]                        in_vs2,
    input  logic [TAG_WIDTH-1:0]                 in_tag,
    output logic [AW-1:0]                        rd_addr_1,
    output logic [AW-1:0]                        rd_addr_2,
    input  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  vrf_data_1,
    input  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  vrf_data_2,
    input  logic [ELEMENTS-1:0]                  wb_en,
    input  logic [AW-1:0]                        wb_addr,
    input  logic [ELEMENTS*DATA_WIDTH-1:0]       wb_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  out_op1,
    output logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  out_op2,
    output logic [TAG_WIDTH-1:0]                 out_tag,
    output logic [31:0]                          conflict_cnt
);
    typedef logic [ELEMENTS-1:0][DATA_WIDTH-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, RETRY, CAPT, VALID} state_t;

    state_t               state_q;
    logic [AW-1:0]        vs1_q, vs2_q;
    logic [TAG_WIDTH-1:0] tag_q;
    vec_t                 op1_q, op2_q;
    logic [31:0]          cnt_q;

    logic   wb_any, is_valid, accept, read_cyc;
    state_t rd_state_d;

    function automatic vec_t merge(input vec_t x, input logic [AW-1:0] src,
                                   input logic [ELEMENTS-1:0] en, input logic [AW-1:0] addr,
                                   input logic [ELEMENTS*DATA_WIDTH-1:0] data);
        vec_t r;
        r = x;
        for (int e = 0; e < ELEMENTS; e++) begin
            if (en[e] && (addr == src)) r[e] = data[e*DATA_WIDTH +: DATA_WIDTH];
        end
        return r;
    endfunction

    assign wb_any     = |wb_en;
    assign is_valid   = (state_q == VALID);
    assign in_ready   = !reset && ((state_q == IDLE) || (is_valid && out_ready));
    assign accept     = in_valid && in_ready;
    assign read_cyc   = accept || (state_q == RETRY);
    // A write at the read edge corrupts read port 1, so the read only counts when the write port is idle.
    assign rd_state_d = wb_any ? RETRY : CAPT;

    assign rd_addr_1 = reset ? '0 : (accept ? in_vs1 : vs1_q);
    assign rd_addr_2 = reset ? '0 : (accept ? in_vs2 : vs2_q);

    assign out_valid    = is_valid;
    assign out_op1      = is_valid ? merge(op1_q, vs1_q, wb_en, wb_addr, wb_data) : op1_q;
    assign out_op2      = is_valid ? merge(op2_q, vs2_q, wb_en, wb_addr, wb_data) : op2_q;
    assign out_tag      = tag_q;
    assign conflict_cnt = cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= IDLE;
            vs1_q   <= '0;
            vs2_q   <= '0;
            tag_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                vs1_q <= in_vs1;
                vs2_q <= in_vs2;
                tag_q <= in_tag;
            end
            if (read_cyc && wb_any && (cnt_q != 32'hFFFF_FFFF)) cnt_q <= cnt_q + 32'd1;
            case (state_q)
                IDLE:  if (accept) state_q <= rd_state_d;
                RETRY: state_q <= rd_state_d;
                CAPT: begin
                    op1_q   <= merge(vrf_data_1, vs1_q, wb_en, wb_addr, wb_data);
                    op2_q   <= merge(vrf_data_2, vs2_q, wb_en, wb_addr, wb_data);
                    state_q <= VALID;
                end
                VALID: begin
                    op1_q <= merge(op1_q, vs1_q, wb_en, wb_addr, wb_data);
                    op2_q <= merge(op2_q, vs2_q, wb_en, wb_addr, wb_data);
                    if (out_ready) state_q <= accept ? rd_state_d : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vrf_operand_fetch.sv
// Bench for vrf_operand_fetch: VRF model with write-corrupted port 1, directed stimulus, scoreboard monitor.
module tb_vrf_operand_fetch;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic         reset, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]   in_vs1, in_vs2, rd_addr_1, rd_addr_2, wb_addr;
    logic [15:0]  in_tag, out_tag;
    logic [127:0] vrf_data_1, vrf_data_2, wb_data, out_op1, out_op2;
    logic [3:0]   wb_en;
    logic [31:0]  conflict_cnt;

    vrf_operand_fetch dut (
        .clk_i(clk_i), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_vs1(in_vs1), .in_vs2(in_vs2), .in_tag(in_tag),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .vrf_data_1(vrf_data_1), .vrf_data_2(vrf_data_2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_tag(out_tag),
        .conflict_cnt(conflict_cnt)
    );

    typedef struct packed {
        logic [127:0] op1;
        logic [127:0] op2;
        logic [15:0]  tag;
    } exp_t;

    localparam logic [127:0] V3  = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] V3B = {32'h55, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] V5  = {32'd8, 32'd7, 32'd6, 32'd5};
    localparam logic [127:0] V5F = {32'd8, 32'hDEAD, 32'd6, 32'hDEAD};
    localparam logic [127:0] V7  = {32'h74, 32'h73, 32'h72, 32'h71};

    exp_t         exp_q[$];
    int           hs_cyc[$];
    int           n_chk = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic [4:0]   ra1, ra2;
    logic [127:0] mem [32];

    always @(posedge clk_i) cyc <= cyc + 1;

    // VRF: one-cycle read latency; port 1 returns garbage when a write shares the edge.
    always @(posedge clk_i) begin
        vrf_data_1 <= (|wb_en) ? {4{32'hBAD0_BAD0}} : mem[rd_addr_1];
        vrf_data_2 <= mem[rd_addr_2];
        for (int e = 0; e < 4; e++)
            if (wb_en[e]) mem[wb_addr][e*32 +: 32] <= wb_data[e*32 +: 32];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_output: tag %h with empty scoreboard", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_op1", out_op1, e.op1);
                    chk("sb_op2", out_op2, e.op2);
                    chk("sb_tag", {112'd0, out_tag}, {112'd0, e.tag});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [15:0] t, output int acc);
        in_valid = 1'b1; in_vs1 = a; in_vs2 = b; in_tag = t;
        acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            @(negedge clk_i);
            if (in_ready) begin
                acc = cyc;
                ra1 = rd_addr_1;
                ra2 = rd_addr_2;
            end
            step();
        end
        in_valid = 1'b0;
        chk("accepted", {127'd0, acc >= 0}, 128'd1);
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int i = 0; i < 30 && c < 0; i++) begin
            @(negedge clk_i);
            if (out_valid) c = cyc;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int t0, ta, tb, c;
        reset = 1'b1; in_valid = 1'b0; in_vs1 = '0; in_vs2 = '0; in_tag = '0; out_ready = 1'b1;
        wb_en = 4'hF; wb_addr = 5'd3; wb_data = V3;
        step(); wb_addr = 5'd5; wb_data = V5;
        step(); wb_addr = 5'd7; wb_data = V7;
        step(); wb_en = 4'h0;
        @(negedge clk_i);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_conflict", {96'd0, conflict_cnt}, 128'd0);
        chk("rst_rd_addr_1", {123'd0, rd_addr_1}, 128'd0);
        chk("rst_out_tag", {112'd0, out_tag}, 128'd0);
        step(); reset = 1'b0;
        @(negedge clk_i);
        chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
        step();

        // basic read
        exp_q.push_back({V3, V5, 16'h00AA});
        send(5'd3, 5'd5, 16'h00AA, t0);
        chk("t1_rd_addr_1", {123'd0, ra1}, 128'd3);
        chk("t1_rd_addr_2", {123'd0, ra2}, 128'd5);
        @(negedge clk_i);
        chk("t1_capt_not_valid", {127'd0, out_valid}, 128'd0);
        wait_valid(c);
        chk("t1_latency", 128'(c - t0), 128'd2);
        chk("t1_conflict", {96'd0, conflict_cnt}, 128'd0);
        step();

        // collision retry: three write cycles starting on the accept cycle
        exp_q.push_back({V3, V5, 16'h0002});
        wb_en = 4'b0001; wb_addr = 5'd9; wb_data = {4{32'h99}};
        send(5'd3, 5'd5, 16'h0002, t0);
        @(negedge clk_i);
        chk("t2_retry_in_ready", {127'd0, in_ready}, 128'd0);
        step();
        step(); wb_en = 4'h0;
        wait_valid(c);
        chk("t2_latency", 128'(c - t0), 128'd5);
        chk("t2_conflict", {96'd0, conflict_cnt}, 128'd3);
        step();

        // forward during CAPT
        exp_q.push_back({V3, V5F, 16'h00C3});
        send(5'd3, 5'd5, 16'h00C3, t0);
        wb_en = 4'b0101; wb_addr = 5'd5; wb_data = {32'hFFFF_FFFF, 32'hDEAD, 32'hFFFF_FFFF, 32'hDEAD};
        step(); wb_en = 4'h0;
        wait_valid(c);
        chk("t3_latency", 128'(c - t0), 128'd2);
        step();

        // backpressure with a forward in the second held cycle
        out_ready = 1'b0;
        exp_q.push_back({V3B, V5F, 16'h0B0B});
        send(5'd3, 5'd5, 16'h0B0B, t0);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                wb_en = 4'b1000; wb_addr = 5'd3; wb_data = {32'h55, 96'd0};
            end else begin
                wb_en = 4'h0;
            end
            @(negedge clk_i);
            chk("t4_valid_held", {127'd0, out_valid}, 128'd1);
            chk("t4_in_ready_low", {127'd0, in_ready}, 128'd0);
            chk("t4_tag_stable", {112'd0, out_tag}, {112'd0, 16'h0B0B});
            chk("t4_op2_stable", out_op2, V5F);
            chk("t4_op1", out_op1, (i == 0) ? V3 : V3B);
            step();
        end
        wb_en = 4'h0; out_ready = 1'b1;
        @(negedge clk_i);
        chk("t4_release_in_ready", {127'd0, in_ready}, 128'd1);
        step();
        @(negedge clk_i);
        chk("t4_single_transfer", {127'd0, out_valid}, 128'd0);
        chk("t4_hs_count", 128'(hs_cyc.size()), 128'd4);
        step();

        // back-to-back
        exp_q.push_back({V3B, V7, 16'h0A01});
        exp_q.push_back({V7, V3B, 16'h0A02});
        send(5'd3, 5'd7, 16'h0A01, ta);
        send(5'd7, 5'd3, 16'h0A02, tb);
        chk("t5_second_accept", 128'(tb - ta), 128'd2);
        wait_valid(c);
        chk("t5_b_latency", 128'(c - tb), 128'd2);
        step();
        chk("t5_pulse_gap", 128'((hs_cyc.size() >= 6) ? hs_cyc[5] - hs_cyc[4] : 0), 128'd2);

        // reset while retrying, with a new micro-op pending
        wb_en = 4'b0001; wb_addr = 5'd9; wb_data = {4{32'h77}};
        send(5'd3, 5'd5, 16'h0DD0, t0);
        reset = 1'b1; in_valid = 1'b1; in_vs1 = 5'd7; in_vs2 = 5'd7; in_tag = 16'h0FFF;
        @(negedge clk_i);
        chk("t6_pre_rst_conflict", {96'd0, conflict_cnt}, 128'd4);
        chk("t6_rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("t6_rst_rd_addr_1", {123'd0, rd_addr_1}, 128'd0);
        chk("t6_rst_rd_addr_2", {123'd0, rd_addr_2}, 128'd0);
        step(); reset = 1'b0; in_valid = 1'b0; wb_en = 4'h0;
        @(negedge clk_i);
        chk("t6_out_valid", {127'd0, out_valid}, 128'd0);
        chk("t6_conflict", {96'd0, conflict_cnt}, 128'd0);
        chk("t6_idle_in_ready", {127'd0, in_ready}, 128'd1);
        chk("t6_addr_cleared", {123'd0, rd_addr_1}, 128'd0);
        chk("t6_tag_cleared", {112'd0, out_tag}, 128'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk_i);
            chk("t6_no_stale", {127'd0, out_valid}, 128'd0);
        end

        chk("final_hs_count", 128'(hs_cyc.size()), 128'd6);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
